wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer master: the initiator end of the bus that the calculation cores serve as slaves.
- Converts a valid/ready command stream (address, data, we, sel) into one Wishbone cycle per command.
- Returns the read data, or a timeout flag, on a valid/ready response stream.
- Used by on-chip sequencers and LA-driven test logic to program and poll slave register banks without the management SoC.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must be a multiple of 8.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 255, maximum cycles STB stays high waiting for ACK; range 1..65535.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  master can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  target address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  SEL_WIDTH  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumer ready.
- rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout_o  out  1  transfer ended by timeout, not by ACK.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_sel_o  out  SEL_WIDTH  Wishbone SEL.
- wbm_adr_o  out  ADDR_WIDTH  Wishbone address.
- wbm_dat_o  out  DATA_WIDTH  Wishbone write data.
- wbm_ack_i  in  1  Wishbone ACK.
- wbm_dat_i  in  DATA_WIDTH  Wishbone read data.

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output 0 except cmd_ready_o, which is 1 in IDLE. Timeout counter cleared.
- Reset during BUS or RESP aborts immediately: CYC/STB low after that edge, and any pending response is discarded.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o: register we/adr/dat/sel onto the wbm_* outputs, set CYC = STB = 1, clear the counter, go to BUS.
- BUS:
  - cmd_ready_o = 0. CYC, STB and all wbm_* outputs held stable. The counter increments each cycle.
  - On wbm_ack_i = 1: drop CYC/STB at the next edge. rsp_dat_o = wbm_dat_i for a read, 0 for a write. rsp_timeout_o = 0. Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ACK: drop CYC/STB, set rsp_dat_o = 0 and rsp_timeout_o = 1, go to RESP.
  - ACK in the same cycle as timeout expiry: ACK wins, rsp_timeout_o = 0.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_timeout_o held stable.
  - On rsp_ready_i: clear rsp_valid_o and go to IDLE.
  - cmd_ready_o stays 0 until back in IDLE (one transfer outstanding at most).
- Latency:
  - Command accepted at edge N → STB visible in cycle N+1.
  - ACK sampled at edge M → rsp_valid_o in cycle M+1.
  - With a zero-wait slave, accept-to-response is 2 cycles.
  - Back-to-back throughput is at least 3 cycles per transfer; rsp_ready_i tied to 1 gives exactly 3.
- ACK while not in BUS is ignored; no response is generated.
- wbm_dat_o and wbm_sel_o are driven for reads as well; slaves ignore them.
- wbm_* outputs keep their last value in IDLE/RESP; only CYC/STB qualify them.

Optional Feature:
- Macro WB_CMD_MASTER_STATS_EN.
- Defined: adds outputs stat_txn_o [15:0] and stat_tmo_o [15:0].
  - stat_txn_o counts transfers completed by ACK.
  - stat_tmo_o counts timeouts.
  - Both wrap at 0xFFFF→0 and clear on reset.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - FSM state enum {ST_IDLE, ST_BUS, ST_RESP}.
  - Default width constants WB_ADDR_W = 32, WB_DATA_W = 32.
  - Timeout counter width function clog2(TIMEOUT_CYCLES+1).
- Single module; no sub-module is needed.

Test Plan:
- Write 0xDEADBEEF to adr 0x3000_0004, sel 0xF, slave ACKs on the first STB cycle → wbm_* match the command, CYC/STB high exactly 1 cycle, rsp_valid with rsp_dat_o = 0 and rsp_timeout_o = 0, 2 cycles after accept.
- Read adr 0x3000_0008, slave inserts 3 wait states then returns 0x1234_5678 → STB high 4 cycles, rsp_dat_o = 0x12345678.
- Read with slave never ACKing, TIMEOUT_CYCLES = 8 → CYC/STB high 8 cycles, then rsp_timeout_o = 1 and rsp_dat_o = 0.
- ACK on exactly the 8th cycle with TIMEOUT_CYCLES = 8 → rsp_timeout_o = 0 and data captured.
- rsp_ready_i held low 5 cycles while cmd_valid_i stays high → response stable, cmd_ready_o = 0 throughout, second command accepted only after the handshake.
- Reset asserted during BUS → CYC/STB = 0 and rsp_valid_o = 0 after the next edge.
- Stray ACK in IDLE → no response.
- With STATS_EN: 3 ACKed transfers plus 1 timeout → stat_txn_o = 3, stat_tmo_o = 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone master definitions: FSM state encoding, default bus widths
// and the sizing helper for the ACK timeout counter.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Bits needed to count 0..cycles inclusive.
    function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master. Each command accepted on the
// valid/ready command stream becomes one CYC/STB cycle; the read data (or a
// timeout flag when the slave never ACKs) returns on the response stream.
// One transfer is outstanding at most.
// Optional: define WB_CMD_MASTER_STATS_EN to add the 16-bit ACK/timeout
// event counters stat_txn_o and stat_tmo_o.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = WB_DATA_W,
    parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_timeout_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [SEL_WIDTH-1:0]  wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i
`ifdef WB_CMD_MASTER_STATS_EN
    ,
    output logic [15:0]           stat_txn_o,
    output logic [15:0]           stat_tmo_o
`endif
);

    localparam int unsigned          CNT_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                    rsp_tmo_q, rsp_tmo_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;

    // Next-state and next-output logic for the IDLE -> BUS -> RESP cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_tmo_d   = rsp_tmo_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any bus cycle or response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_tmo_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_tmo_q   <= rsp_tmo_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_timeout_o = rsp_tmo_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = stb_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;

`ifdef WB_CMD_MASTER_STATS_EN
    logic [15:0] txn_q, txn_d;
    logic [15:0] tmo_q, tmo_d;

    // Count ACK-terminated and timeout-terminated transfers; both wrap.
    always_comb begin
        txn_d = txn_q;
        tmo_d = tmo_q;
        if (state_q == ST_BUS) begin
            if (wbm_ack_i) begin
                txn_d = txn_q + 16'd1;
            end else if (cnt_q == CNT_LAST) begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    // Statistics counter flops.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            txn_q <= '0;
            tmo_q <= '0;
        end else begin
            txn_q <= txn_d;
            tmo_q <= tmo_d;
        end
    end

    assign stat_txn_o = txn_q;
    assign stat_tmo_o = tmo_q;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master with a small Wishbone slave model.
module tb_wb_cmd_master;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_tmo;
    logic          wbm_cyc;
    logic          wbm_stb;
    logic          wbm_we;
    logic [SW-1:0] wbm_sel;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_wdat;
    logic          wbm_ack;
    logic [DW-1:0] wbm_rdat;
`ifdef WB_CMD_MASTER_STATS_EN
    logic [15:0]   stat_txn;
    logic [15:0]   stat_tmo;
`endif

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SEL_WIDTH      (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_adr_i     (cmd_adr),
        .cmd_dat_i     (cmd_dat),
        .cmd_sel_i     (cmd_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_timeout_o (rsp_tmo),
        .wbm_cyc_o     (wbm_cyc),
        .wbm_stb_o     (wbm_stb),
        .wbm_we_o      (wbm_we),
        .wbm_sel_o     (wbm_sel),
        .wbm_adr_o     (wbm_adr),
        .wbm_dat_o     (wbm_wdat),
        .wbm_ack_i     (wbm_ack),
        .wbm_dat_i     (wbm_rdat)
`ifdef WB_CMD_MASTER_STATS_EN
        ,
        .stat_txn_o    (stat_txn),
        .stat_tmo_o    (stat_tmo)
`endif
    );

    // Slave model: ACK after slv_wait wait states unless slv_never; slv_stray forces ACK.
    int            slv_wait  = 0;
    bit            slv_never = 1'b0;
    bit            slv_stray = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int            stb_cnt   = 0;

    always @(posedge clk) stb_cnt <= (wbm_cyc && wbm_stb) ? stb_cnt + 1 : 0;

    assign wbm_ack  = slv_stray | (wbm_cyc & wbm_stb & ~slv_never & (stb_cnt == slv_wait));
    assign wbm_rdat = slv_rdata;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          tmo;
        logic [31:0]   lat;
    } rsp_exp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic [31:0]   len;
    } bus_exp_t;

    rsp_exp_t rsp_q[$];
    bus_exp_t bus_q[$];

    int n_chk     = 0;
    int n_fail    = 0;
    int n_rsp     = 0;
    int cyc_n     = 0;
    int acc_cyc   = 0;
    int first_cyc = 0;
    bit in_rsp    = 1'b0;
    int stb_run   = 0;
    bus_exp_t cur_bus = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: bus-phase and response checks, sampled mid-low-phase.
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (wbm_stb) begin
                if (stb_run == 0) begin
                    if (bus_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_stb: actual=STB high required=no bus cycle");
                        cur_bus = '0;
                    end else begin
                        cur_bus = bus_q.pop_front();
                        chk("bus_we",  64'(wbm_we),   64'(cur_bus.we));
                        chk("bus_adr", 64'(wbm_adr),  64'(cur_bus.adr));
                        chk("bus_dat", 64'(wbm_wdat), 64'(cur_bus.dat));
                        chk("bus_sel", 64'(wbm_sel),  64'(cur_bus.sel));
                    end
                end
                chk("cyc_with_stb", 64'(wbm_cyc), 64'(1));
                stb_run++;
            end else if (stb_run != 0) begin
                chk("stb_len", 64'(stb_run), 64'(cur_bus.len));
                stb_run = 0;
            end

            if (rsp_valid && !in_rsp) begin
                in_rsp    = 1'b1;
                first_cyc = cyc_n;
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: actual=rsp_valid required=no response");
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                    chk("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
                    chk("rsp_lat", 64'(first_cyc - acc_cyc), 64'(e.lat));
                end
                in_rsp = 1'b0;
                n_rsp++;
            end
        end
    end

    // Called at a negedge with cmd_valid high; returns at the negedge after the accept edge.
    task automatic wait_accept();
        for (int k = 0; k < 100; k++) begin
            if (cmd_ready) begin
                @(negedge clk);
                acc_cyc = cyc_n;
                return;
            end
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: actual=cmd_ready low required=accept within 100 cycles");
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 100; k++) begin
            if (n_rsp >= target) return;
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL rsp_timeout: actual=%0d responses required=%0d", n_rsp, target);
    endtask

    task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, input int wait_n, input bit never,
                          input logic [DW-1:0] rdata, input logic [DW-1:0] exp_dat,
                          input logic exp_tmo, input int len);
        int target;
        slv_wait  = wait_n;
        slv_never = never;
        slv_rdata = rdata;
        bus_q.push_back('{we, adr, dat, sel, 32'(len)});
        rsp_q.push_back('{exp_dat, exp_tmo, 32'(len)});
        target    = n_rsp + 1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        wait_rsp(target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int c;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_dat",   64'(rsp_dat),   64'(0));
        chk("rst_rsp_tmo",   64'(rsp_tmo),   64'(0));
        chk("rst_cyc",       64'(wbm_cyc),   64'(0));
        chk("rst_stb",       64'(wbm_stb),   64'(0));
        chk("rst_adr",       64'(wbm_adr),   64'(0));
        chk("rst_sel",       64'(wbm_sel),   64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Reset during BUS aborts the cycle; no response follows.
        slv_never = 1'b1;
        bus_q.push_back('{1'b0, 32'h3000_0010, 32'h1111_2222, 4'hF, 32'd2});
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0010;
        cmd_dat   = 32'h1111_2222;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cyc",       64'(wbm_cyc),   64'(0));
        chk("abort_stb",       64'(wbm_stb),   64'(0));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Stray ACK in IDLE produces nothing.
        slv_stray = 1'b1;
        repeat (2) @(negedge clk);
        slv_stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("stray_cmd_ready", 64'(cmd_ready), 64'(1));

        // Zero-wait write, 3-wait read, timeout, ACK on the last allowed cycle.
        do_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'hCAFE_F00D, 32'h0,          1'b0, 1);
        do_cmd(1'b0, 32'h3000_0008, 32'h5555_AAAA, 4'h3, 3, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 4);
        do_cmd(1'b0, 32'h3000_000C, 32'h0,         4'hF, 0, 1'b1, 32'hBAD0_BAD0, 32'h0,          1'b1, 8);
        do_cmd(1'b0, 32'h3000_0010, 32'h0,         4'hF, 7, 1'b0, 32'h8765_4321, 32'h8765_4321, 1'b0, 8);

`ifdef WB_CMD_MASTER_STATS_EN
        chk("stat_txn", 64'(stat_txn), 64'(3));
        chk("stat_tmo", 64'(stat_tmo), 64'(1));
`endif

        // Back-pressure: response held 5 cycles, next command waits for the handshake.
        rsp_ready = 1'b0;
        slv_wait  = 0;
        slv_never = 1'b0;
        slv_rdata = 32'hA5A5_0001;
        bus_q.push_back('{1'b0, 32'h3000_0020, 32'h0, 4'h1, 32'd1});
        rsp_q.push_back('{32'hA5A5_0001, 1'b0, 32'd1});
        bus_q.push_back('{1'b1, 32'h3000_0024, 32'h0BAD_CAFE, 4'hC, 32'd1});
        rsp_q.push_back('{32'h0, 1'b0, 32'd1});
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0020;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h1;
        cmd_valid = 1'b1;
        wait_accept();
        cmd_we  = 1'b1;
        cmd_adr = 32'h3000_0024;
        cmd_dat = 32'h0BAD_CAFE;
        cmd_sel = 4'hC;
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        slv_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_rsp_dat",   64'(rsp_dat),   64'(32'hA5A5_0001));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        c = cyc_n;
        chk("bp_cmd_ready_hs", 64'(cmd_ready), 64'(0));
        wait_accept();
        cmd_valid = 1'b0;
        chk("bp_accept_gap", 64'(acc_cyc - c), 64'(2));
        wait_rsp(n_rsp + 1);
        repeat (3) @(negedge clk);
        chk("end_queues_empty", 64'(rsp_q.size() + bus_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
